// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream master port between N_SRC sources.
// The grant is taken in IDLE and held until the granted source's tlast beat transfers.
module axis_packet_arbiter #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 2
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [N_SRC-1:0]            s_tvalid,
    output logic [N_SRC-1:0]            s_tready,
    input  logic [N_SRC*DATA_W-1:0]     s_tdata,
    input  logic [N_SRC*DATA_W/8-1:0]   s_tkeep,
    input  logic [N_SRC-1:0]            s_tlast,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic [DATA_W/8-1:0]         m_tkeep,
    output logic                        m_tlast,
    output logic [ID_W-1:0]             m_tid,
    output logic                        grant_active,
    output logic [ID_W-1:0]             grant_idx
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned SUM_W  = ID_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_grant;
    logic [ID_W-1:0] w_grant_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_rr_ptr_nxt;
    logic            w_pick_found;
    logic [ID_W-1:0] w_pick_idx;
    logic [ID_W-1:0] w_grant_inc;

    // First valid source scanning upward from the round-robin pointer, wrapping at N_SRC.
    always_comb begin
        logic [SUM_W-1:0] w_sum;
        w_sum        = '0;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_sum = SUM_W'(r_rr_ptr) + SUM_W'(k);
            if (w_sum >= SUM_W'(N_SRC)) begin
                w_sum = w_sum - SUM_W'(N_SRC);
            end
            if (!w_pick_found && s_tvalid[ID_W'(w_sum)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = ID_W'(w_sum);
            end
        end
    end

    assign w_grant_inc = (r_grant == ID_W'(N_SRC - 1)) ? '0 : r_grant + ID_W'(1);

    // Zero-latency passthrough of the granted source while BUSY; everything quiet in IDLE.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_state == ST_BUSY && r_grant == ID_W'(i)) begin
                m_tvalid    = s_tvalid[i];
                m_tdata     = s_tdata[i*DATA_W +: DATA_W];
                m_tkeep     = s_tkeep[i*KEEP_W +: KEEP_W];
                m_tlast     = s_tlast[i];
                s_tready[i] = m_tready;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_pick_idx;
                end
            end
            ST_BUSY: begin
                if (m_tvalid && m_tready && m_tlast) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = w_grant_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign m_tid        = r_grant;
    assign grant_idx    = r_grant;
    assign grant_active = (r_state == ST_BUSY);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: packet-queue sources, per-cycle reference model of the
// round-robin grant, directed scenarios with literal expectations, then a randomized run.
module tb_axis_packet_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N*KW-1:0] s_tkeep = '0;
    logic [N-1:0]    s_tlast = '0;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [IW-1:0]   m_tid;
    logic            grant_active;
    logic [IW-1:0]   grant_idx;

    always #5 clk = ~clk;

    axis_packet_arbiter #(.N_SRC(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .arst(arst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid),
        .grant_active(grant_active), .grant_idx(grant_idx)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t q[N][$];
    logic  vld[N];
    logic  rdy;
    int    pv = 100;
    int    pr = 100;
    int    rdy_force = 1;

    // Reference model: who owns the output, and which source has top priority next.
    int mb, mg, mp;
    int cyc;
    int checks = 0;
    int errors = 0;

    int            xs[$];
    int            xc[$];
    logic [DW-1:0] xd[$];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", n, act, exp, cyc);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mp + k) % N;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int i = 0; i < N; i++) n += q[i].size();
        return n;
    endfunction

    task automatic add_pkt(input int s, input int len, input int tag);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d = (DW'(s) << 24) | (DW'(tag & 255) << 8) | DW'(j);
            b.k = KW'($urandom_range(15, 1));
            b.l = (j == len - 1);
            q[s].push_back(b);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            vld[i] = 1'b0;
        end
        mb = 0; mg = 0; mp = 0;
        xs.delete(); xc.delete(); xd.delete();
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
    endtask

    task automatic reset_all();
        arst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        arst = 1'b0;
    endtask

    // One cycle: drive at the falling edge, compare just after, advance the model for the next rising edge.
    task automatic step();
        logic [N-1:0] er;
        int           w;
        logic         last;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (q[i].size() == 0) vld[i] = 1'b0;
            else if (!vld[i]) vld[i] = ($urandom_range(99) < pv);
        end
        rdy = (rdy_force >= 0) ? (rdy_force != 0) : ($urandom_range(99) < pr);
        m_tready = rdy;
        for (int i = 0; i < N; i++) begin
            s_tvalid[IW'(i)] = vld[i];
            if (q[i].size() > 0) begin
                s_tdata[i*DW +: DW] = q[i][0].d;
                s_tkeep[i*KW +: KW] = q[i][0].k;
                s_tlast[IW'(i)]     = q[i][0].l;
            end else begin
                s_tdata[i*DW +: DW] = DW'($urandom);
                s_tkeep[i*KW +: KW] = KW'($urandom);
                s_tlast[IW'(i)]     = 1'($urandom);
            end
        end
        #1;
        er = '0;
        if (mb != 0) er[IW'(mg)] = rdy;
        chk("s_tready", 64'(s_tready), 64'(er));
        chk("m_tvalid", 64'(m_tvalid), 64'((mb != 0) && vld[mg]));
        chk("grant_active", 64'(grant_active), 64'(mb != 0));
        chk("m_tid", 64'(m_tid), 64'(mg));
        chk("grant_idx", 64'(grant_idx), 64'(mg));
        if (mb != 0 && vld[mg]) begin
            chk("m_tdata", 64'(m_tdata), 64'(q[mg][0].d));
            chk("m_tkeep", 64'(m_tkeep), 64'(q[mg][0].k));
            chk("m_tlast", 64'(m_tlast), 64'(q[mg][0].l));
        end
        if (mb != 0) begin
            if (vld[mg] && rdy) begin
                xs.push_back(mg);
                xc.push_back(cyc);
                xd.push_back(q[mg][0].d);
                last = q[mg][0].l;
                void'(q[mg].pop_front());
                vld[mg] = 1'b0;
                if (last) begin
                    mb = 0;
                    mp = (mg + 1) % N;
                end
            end
        end else begin
            w = pick();
            if (w >= 0) begin
                mb = 1;
                mg = w;
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((mb != 0 || pending() != 0) && n < budget) begin
            step();
            n++;
        end
        if (mb != 0 || pending() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%0d required=0", pending(), mb);
        end
    endtask

    task automatic run_until_xfers(input int nx, input int budget);
        int n;
        n = 0;
        while (xs.size() < nx && n < budget) begin
            step();
            n++;
        end
        if (xs.size() < nx) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout got=%0d required=%0d", xs.size(), nx);
        end
    endtask

    initial begin
        int c0;
        int exp3[7];
        cyc = 0;
        clear_model();
        #2;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_grant_active", 64'(grant_active), 64'(0));
        chk("rst_m_tid", 64'(m_tid), 64'(0));
        reset_all();

        // Lone source 1, three beats, ready held high.
        rdy_force = 1; pv = 100;
        add_pkt(1, 3, 1);
        c0 = cyc;
        run_until_idle(20);
        chk("t1_n", 64'(xs.size()), 64'(3));
        for (int j = 0; j < 3 && j < xs.size(); j++) begin
            chk("t1_src", 64'(xs[j]), 64'(1));
            chk("t1_cyc", 64'(xc[j]), 64'(c0 + 1 + j));
            chk("t1_data", 64'(xd[j]), 64'(32'h0100_0100 + j));
        end
        step();
        chk("t1_idle", 64'(grant_active), 64'(0));

        // All four sources with 2-beat packets, source 0 queues a second one.
        reset_all();
        for (int s = 0; s < N; s++) add_pkt(s, 2, 2);
        add_pkt(0, 2, 3);
        c0 = cyc;
        run_until_idle(40);
        chk("t2_n", 64'(xs.size()), 64'(10));
        for (int j = 0; j < 10 && j < xs.size(); j++) begin
            chk("t2_src", 64'(xs[j]), 64'((j / 2) % 4));
            chk("t2_cyc", 64'(xc[j]), 64'(c0 + 1 + 3 * (j / 2) + (j % 2)));
        end

        // Back-pressure on source 0 after its first beat while the others wait.
        reset_all();
        add_pkt(0, 4, 0);
        for (int s = 1; s < N; s++) add_pkt(s, 1, 0);
        rdy_force = 1;
        run_until_xfers(1, 10);
        rdy_force = 0;
        repeat (5) begin
            step();
            chk("t3_hold_data", 64'(m_tdata), 64'(32'h0000_0001));
            chk("t3_s_tready", 64'(s_tready), 64'(0));
            chk("t3_grant", 64'(grant_idx), 64'(0));
        end
        rdy_force = 1;
        run_until_idle(40);
        exp3 = '{0, 0, 0, 0, 1, 2, 3};
        chk("t3_n", 64'(xs.size()), 64'(7));
        for (int j = 0; j < 7 && j < xs.size(); j++) chk("t3_order", 64'(xs[j]), 64'(exp3[j]));

        // Source 2 requests mid-flight of a 4-beat source 0 packet.
        reset_all();
        add_pkt(0, 4, 4);
        run_until_xfers(1, 10);
        add_pkt(2, 1, 4);
        run_until_idle(30);
        chk("t4_n", 64'(xs.size()), 64'(5));
        if (xs.size() >= 5) begin
            chk("t4_src", 64'(xs[4]), 64'(2));
            chk("t4_bubble", 64'(xc[4] - xc[3]), 64'(2));
        end

        // Asynchronous reset in the middle of a source 3 packet.
        reset_all();
        add_pkt(3, 4, 5);
        run_until_xfers(2, 10);
        #2;
        arst = 1'b1;
        #1;
        chk("t5_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("t5_s_tready", 64'(s_tready), 64'(0));
        chk("t5_grant_active", 64'(grant_active), 64'(0));
        chk("t5_m_tid", 64'(m_tid), 64'(0));
        clear_model();
        @(negedge clk);
        arst = 1'b0;
        add_pkt(0, 1, 6);
        add_pkt(3, 1, 6);
        run_until_idle(20);
        chk("t5_n", 64'(xs.size()), 64'(2));
        if (xs.size() >= 2) begin
            chk("t5_first", 64'(xs[0]), 64'(0));
            chk("t5_second", 64'(xs[1]), 64'(3));
        end

        // Pointer wrap: after a grant to 3, sources 1 and 3 compete.
        reset_all();
        add_pkt(3, 1, 7);
        run_until_idle(10);
        add_pkt(1, 1, 8);
        add_pkt(3, 1, 8);
        run_until_idle(20);
        chk("t6_n", 64'(xs.size()), 64'(3));
        if (xs.size() >= 3) begin
            chk("t6_wrap", 64'(xs[1]), 64'(1));
            chk("t6_next", 64'(xs[2]), 64'(3));
        end

        // Randomized traffic with random gaps and back-pressure.
        reset_all();
        pv = 70; pr = 70; rdy_force = -1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(99) < 8) begin
                int s;
                s = $urandom_range(N - 1);
                if (q[s].size() < 8) add_pkt(s, $urandom_range(5, 1), c);
            end
            step();
        end
        pv = 100; rdy_force = 1;
        run_until_idle(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
